// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one single-port memory between fetch and data ports; one
//            transaction in flight. Build option ARB_ROUND_ROBIN_EN.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              res,
    input  logic              instr_req,
    input  logic [ADDR_W-1:0] instr_adr,
    output logic              instr_gnt,
    output logic              instr_r_valid,
    output logic [DATA_W-1:0] instr_read,
    input  logic              data_req,
    input  logic [ADDR_W-1:0] data_adr,
    input  logic              data_write_enable,
    input  logic [DATA_W-1:0] data_write,
    output logic              data_gnt,
    output logic              data_r_valid,
    output logic [DATA_W-1:0] data_read,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_adr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_r_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_REQ       = 2'd1;
    localparam logic [1:0] c_RESP      = 2'd2;
    localparam logic       c_OWN_INSTR = 1'b0;
    localparam logic       c_OWN_DATA  = 1'b1;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_owner;
    logic       w_owner_nxt;
    logic       w_owner_req;
    logic       w_arb_data;
    logic       w_issue;

    assign w_owner_req = (r_owner == c_OWN_DATA) ? data_req : instr_req;
    assign w_issue     = (r_state == c_REQ) && w_owner_req;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_owner;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_last_owner <= c_OWN_INSTR;
        end else if (w_issue && mem_gnt) begin
            r_last_owner <= r_owner;
        end
    end

    // On contention the port not served last wins.
    assign w_arb_data = data_req && !(instr_req && (r_last_owner == c_OWN_DATA));
`else
    assign w_arb_data = data_req;
`endif

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state <= c_IDLE;
            r_owner <= c_OWN_INSTR;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        case (r_state)
            c_IDLE: begin
                if (data_req || instr_req) begin
                    w_state_nxt = c_REQ;
                    w_owner_nxt = w_arb_data ? c_OWN_DATA : c_OWN_INSTR;
                end
            end
            c_REQ: begin
                // A withdrawn request aborts without ever reaching memory.
                if (!w_owner_req) begin
                    w_state_nxt = c_IDLE;
                end else if (mem_gnt) begin
                    w_state_nxt = c_RESP;
                end
            end
            c_RESP: begin
                if (mem_r_valid) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_comb begin
        mem_req       = w_issue;
        mem_adr       = '0;
        mem_we        = 1'b0;
        mem_wdata     = '0;
        instr_gnt     = 1'b0;
        data_gnt      = 1'b0;
        instr_r_valid = 1'b0;
        data_r_valid  = 1'b0;
        if (r_state == c_REQ) begin
            if (r_owner == c_OWN_DATA) begin
                mem_adr   = data_adr;
                mem_we    = data_write_enable;
                mem_wdata = data_write;
            end else begin
                mem_adr   = instr_adr;
            end
        end
        instr_gnt     = w_issue && mem_gnt && (r_owner == c_OWN_INSTR);
        data_gnt      = w_issue && mem_gnt && (r_owner == c_OWN_DATA);
        instr_r_valid = (r_state == c_RESP) && mem_r_valid && (r_owner == c_OWN_INSTR);
        data_r_valid  = (r_state == c_RESP) && mem_r_valid && (r_owner == c_OWN_DATA);
    end

    assign instr_read = mem_rdata;
    assign data_read  = mem_rdata;

endmodule
`default_nettype wire
